// File: rtl/fifo_rd_fwft_if.sv
// Downstream valid/ready word stream leaving the read-side FWFT stage.
interface fifo_rd_fwft_if #(
   parameter int DATA_W = 9
);
   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;

   modport master (output m_valid, output m_data, input m_ready);
   modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/fifo_rd_fwft.sv
// Read-side FWFT output stage of the async FIFO: head + skid buffer, credit-based pops.
// Optional accepted-word counter enabled by defining RD_WORD_COUNT_EN.
module fifo_rd_fwft #(
   parameter int DATA_W = 9
`ifdef RD_WORD_COUNT_EN
   ,
   parameter int CNT_W  = 32
`endif
) (
   input  logic              rclk,
   input  logic              rrst,
   input  logic              rempty,
   output logic              rincr,
   input  logic [DATA_W-1:0] rdata,
   fifo_rd_fwft_if.master    m
`ifdef RD_WORD_COUNT_EN
   ,
   output logic [CNT_W-1:0]  word_cnt
`endif
);

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} cnt_t;

   cnt_t              cnt, cnt_nxt;
   logic              inflight;
   logic              take;
   logic              pop;
   logic [2:0]        occ;
   logic              head_ld_rdata;
   logic              head_ld_skid;
   logic              skid_ld;
   logic [DATA_W-1:0] head;
   logic [DATA_W-1:0] skid;

   always_ff @(posedge rclk or negedge rrst) begin
      if (!rrst) begin
         cnt      <= EMPTY;
         inflight <= 1'b0;
      end else begin
         cnt      <= cnt_nxt;
         inflight <= pop;
      end
   end

   always_comb begin
      cnt_nxt = cnt;
      case (cnt)
         EMPTY:   if (inflight) cnt_nxt = ONE;
         ONE: begin
            if (take && !inflight)      cnt_nxt = EMPTY;
            else if (!take && inflight) cnt_nxt = TWO;
         end
         TWO:     if (take) cnt_nxt = ONE;
         default: cnt_nxt = EMPTY;
      endcase
   end

   // Credits count words buffered plus the one in flight; a take frees one this cycle.
   always_comb begin
      m.m_valid     = (cnt != EMPTY);
      take          = m.m_valid & m.m_ready;
      occ           = 3'(cnt) + {2'b00, inflight} - {2'b00, take};
      pop           = rrst & ~rempty & (occ < 3'd2);
      rincr         = pop;
      head_ld_skid  = take & (cnt == TWO);
      head_ld_rdata = inflight & ((cnt == EMPTY) | ((cnt == ONE) & take));
      skid_ld       = inflight & (cnt == ONE) & ~take;
   end

   always_ff @(posedge rclk or negedge rrst) begin
      if (!rrst) begin
         head <= '0;
         skid <= '0;
      end else begin
         if (head_ld_skid)       head <= skid;
         else if (head_ld_rdata) head <= rdata;
         if (skid_ld)            skid <= rdata;
      end
   end

   assign m.m_data = head;

`ifdef RD_WORD_COUNT_EN
   always_ff @(posedge rclk or negedge rrst) begin
      if (!rrst)     word_cnt <= '0;
      else if (take) word_cnt <= word_cnt + 1'b1;
   end
`endif

endmodule

// File: tb/tb_fifo_rd_fwft.sv
// Bench for fifo_rd_fwft: directed phases plus random traffic against a word-count/order model.
module tb_fifo_rd_fwft;
   localparam int DATA_W = 9;
   localparam int CNT_W  = 4;

   logic              rclk = 1'b0;
   logic              rrst;
   logic              rempty;
   logic              rincr;
   logic [DATA_W-1:0] rdata;
`ifdef RD_WORD_COUNT_EN
   logic [CNT_W-1:0]  word_cnt;
`endif

   fifo_rd_fwft_if #(.DATA_W(DATA_W)) mif ();

   fifo_rd_fwft #(
      .DATA_W(DATA_W)
`ifdef RD_WORD_COUNT_EN
      ,
      .CNT_W(CNT_W)
`endif
   ) dut (
      .rclk    (rclk),
      .rrst    (rrst),
      .rempty  (rempty),
      .rincr   (rincr),
      .rdata   (rdata),
      .m       (mif.master)
`ifdef RD_WORD_COUNT_EN
      ,
      .word_cnt(word_cnt)
`endif
   );

   always #5 rclk = ~rclk;

   int total = 0;
   int bad   = 0;

   // Model: source FIFO contents, history of words offered, and pop/arrival/take counts.
   logic [DATA_W-1:0] src[$];
   logic [DATA_W-1:0] sent[$];
   int npop, narr, ntake;
   int ready_pct;
   int gap_pct;
   logic hold_empty;
   int n_rincr, n_valid;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [DATA_W-1:0] w);
      src.push_back(w);
      sent.push_back(w);
   endtask

   task automatic upd_empty();
      rempty = (src.size() == 0) || hold_empty;
   endtask

   task automatic model_reset();
      src.delete();
      sent.delete();
      npop  = 0;
      narr  = 0;
      ntake = 0;
   endtask

   task automatic cycle();
      logic ev, et, ep, p;
      @(negedge rclk);
      ev = (narr - ntake) > 0;
      et = ev & mif.m_ready;
      ep = rrst & ~rempty & ((npop - ntake - int'(et)) < 2);
      chk("m_valid", {31'd0, mif.m_valid}, {31'd0, ev});
      if (ev && ntake < sent.size())
         chk("m_data", {23'd0, mif.m_data}, {23'd0, sent[ntake]});
      chk("rincr", {31'd0, rincr}, {31'd0, ep});
`ifdef RD_WORD_COUNT_EN
      chk("word_cnt", {28'd0, word_cnt}, 32'(ntake % 16));
`endif
      p = rincr;
      n_rincr += int'(rincr);
      n_valid += int'(mif.m_valid);
      @(posedge rclk);
      #1;
      if (et) ntake++;
      narr = npop;
      if (p) npop++;
      if (p && src.size() > 0) rdata = src.pop_front();
      else                     rdata = DATA_W'($urandom);
      hold_empty  = ($urandom_range(99) < gap_pct);
      mif.m_ready = ($urandom_range(99) < ready_pct);
      upd_empty();
   endtask

   initial begin
      int base;
      logic done;
      model_reset();
      gap_pct     = 0;
      ready_pct   = 0;
      hold_empty  = 1'b0;
      n_rincr     = 0;
      n_valid     = 0;
      rrst        = 1'b0;
      rdata       = '0;
      mif.m_ready = 1'b0;
      push(9'h0A5);
      upd_empty();
      #1;
      chk("rst_rincr", {31'd0, rincr}, 32'd0);
      chk("rst_valid", {31'd0, mif.m_valid}, 32'd0);
      chk("rst_data", {23'd0, mif.m_data}, 32'd0);
      cycle();
      cycle();
      rrst = 1'b1;

      // single word, downstream stalled
      for (int i = 0; i < 6; i++) cycle();
      chk("one_pops", npop, 1);
      chk("one_hold", {23'd0, mif.m_data}, 32'h0A5);
      ready_pct   = 100;
      mif.m_ready = 1'b1;
      for (int i = 0; i < 3; i++) cycle();
      chk("one_taken", ntake, 1);

      // 8-word stream at full rate
      for (int i = 0; i < 8; i++) push(DATA_W'(i));
      upd_empty();
      n_rincr = 0;
      n_valid = 0;
      for (int i = 0; i < 12; i++) cycle();
      chk("stream_rincr", n_rincr, 8);
      chk("stream_valid", n_valid, 8);
      chk("stream_taken", ntake, 9);

      // backpressure: only two pops may be outstanding
      ready_pct   = 0;
      mif.m_ready = 1'b0;
      base = npop;
      for (int i = 0; i < 6; i++) push(DATA_W'(9'h020 + i));
      upd_empty();
      for (int i = 0; i < 6; i++) cycle();
      chk("bp_pops", npop - base, 2);
      chk("bp_rincr_low", {31'd0, rincr}, 32'd0);
      ready_pct   = 100;
      mif.m_ready = 1'b1;
      for (int i = 0; i < 12; i++) cycle();
      chk("bp_all_taken", ntake, sent.size());

      // async reset with a buffered word and one in flight
      ready_pct   = 0;
      mif.m_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(DATA_W'(9'h140 + i));
      upd_empty();
      cycle();
      cycle();
      #2;
      rrst = 1'b0;
      #1;
      chk("arst_valid", {31'd0, mif.m_valid}, 32'd0);
      chk("arst_rincr", {31'd0, rincr}, 32'd0);
      chk("arst_data", {23'd0, mif.m_data}, 32'd0);
      model_reset();
      upd_empty();
      cycle();
      rrst = 1'b1;
      for (int i = 0; i < 3; i++) push(DATA_W'(9'h1F0 + i));
      upd_empty();
      ready_pct   = 100;
      mif.m_ready = 1'b1;
      for (int i = 0; i < 10; i++) cycle();
      chk("post_rst_taken", ntake, 3);

      // random traffic, stalls and empty gaps
      gap_pct = 20;
      for (int i = 0; i < 400; i++) begin
         ready_pct = $urandom_range(100);
         for (int k = 0; k < int'($urandom_range(2)); k++) push(DATA_W'($urandom));
         upd_empty();
         cycle();
      end
      gap_pct     = 0;
      hold_empty  = 1'b0;
      ready_pct   = 100;
      mif.m_ready = 1'b1;
      upd_empty();
      done = 1'b0;
      for (int i = 0; i < 1200 && !done; i++) begin
         cycle();
         done = (ntake == sent.size()) && (src.size() == 0);
      end
      chk("drain", ntake, sent.size());
      for (int i = 0; i < 3; i++) cycle();
      chk("final_valid", {31'd0, mif.m_valid}, 32'd0);
`ifdef RD_WORD_COUNT_EN
      chk("final_wc", {28'd0, word_cnt}, 32'(ntake % 16));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
